// File: rtl/vad_frame_scheduler.sv
// Frame-aligned buffer between the MFCC extractor and the classifier: packs coefficient
// words into whole frames, feeds one frame at a time, and smooths predictions with a hangover.
module vad_frame_scheduler #(
  parameter int N_COEF   = 13,
  parameter int FRAMES   = 2,
  parameter int HANGOVER = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tvalid_mfcc_feat,
  input  logic [31:0] mfcc_feat,
  output logic        tvalid_cls_feat,
  output logic [31:0] cls_feat,
  output logic        cls_frame_last,
  input  logic        tvalid_prediction,
  input  logic        prediction,
  output logic        LSVC_Done,
  output logic        LSVC_Result,
  output logic        frame_dropped,
  output logic        cls_timeout,
  output logic        busy
);
  localparam int DEPTH = FRAMES * N_COEF;
  localparam int PW    = $clog2(DEPTH);
  localparam int UW    = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(N_COEF);
  localparam int FW    = $clog2(FRAMES + 1);
  localparam int HW    = $clog2(HANGOVER + 1);
  localparam int WW    = $clog2(TIMEOUT);

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE, FEED, WAIT} state_t;

  function automatic ptr_t wrap_add(ptr_t a, int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return PW'(s);
  endfunction

  logic [31:0]   mem [DEPTH];
  state_t        state, state_nxt;
  ptr_t          wr_ptr, frame_base, rd_ptr, rd_addr;
  logic [CW-1:0] in_cnt, feed_k;
  logic [UW-1:0] used;
  logic [FW-1:0] frames_ready;
  logic [HW-1:0] hang_cnt;
  logic [WW-1:0] wait_cnt;
  logic          bad;

  logic feed_en, feed_last, in_wait, wait_expired, outcome, outcome_p, timeout_hit;
  logic last_word, wr_en, frame_bad, good_commit, bad_commit;
  int   written, used_nxt;

  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frames_ready != '0) state_nxt = FEED;
      FEED:    if (feed_last) state_nxt = WAIT;
      WAIT:    if (tvalid_prediction || wait_expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM decode; a real prediction wins over a same-cycle timeout
  always_comb begin
    feed_en      = (state == FEED);
    feed_last    = feed_en && (feed_k == CW'(N_COEF - 1));
    in_wait      = (state == WAIT);
    wait_expired = in_wait && (wait_cnt == WW'(TIMEOUT - 1));
    outcome      = in_wait && (tvalid_prediction || wait_expired);
    outcome_p    = tvalid_prediction ? prediction : 1'b0;
    timeout_hit  = wait_expired && !tvalid_prediction;
    busy         = (state != IDLE);
  end

  // Input side: a frame that lost any word rolls wr_ptr back to its start on its last word
  always_comb begin
    last_word   = tvalid_mfcc_feat && (in_cnt == CW'(N_COEF - 1));
    wr_en       = tvalid_mfcc_feat && (used < UW'(DEPTH));
    frame_bad   = bad || (tvalid_mfcc_feat && !wr_en);
    good_commit = last_word && !frame_bad;
    bad_commit  = last_word && frame_bad;
    written     = int'(wr_ptr) - int'(frame_base);
    if (written < 0) written = written + DEPTH;
    used_nxt    = int'(used);
    if (wr_en && !bad_commit) used_nxt = used_nxt + 1;
    if (bad_commit)           used_nxt = used_nxt - written;
    if (feed_last)            used_nxt = used_nxt - N_COEF;
    rd_addr     = wrap_add(rd_ptr, 32'(feed_k));
  end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= mfcc_feat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0; frame_base <= '0; rd_ptr <= '0; in_cnt <= '0; used <= '0;
      frames_ready <= '0; hang_cnt <= '0; wait_cnt <= '0; feed_k <= '0; bad <= 1'b0;
      tvalid_cls_feat <= 1'b0; cls_feat <= '0; cls_frame_last <= 1'b0;
      LSVC_Done <= 1'b0; LSVC_Result <= 1'b0; frame_dropped <= 1'b0; cls_timeout <= 1'b0;
    end else begin
      if (tvalid_mfcc_feat) in_cnt <= last_word ? '0 : in_cnt + CW'(1);
      if (last_word)                       bad <= 1'b0;
      else if (tvalid_mfcc_feat && !wr_en) bad <= 1'b1;

      if (bad_commit)  wr_ptr <= frame_base;
      else if (wr_en)  wr_ptr <= wrap_add(wr_ptr, 32'd1);
      if (good_commit) frame_base <= wrap_add(wr_ptr, 32'd1);
      frame_dropped <= bad_commit;
      used <= UW'(used_nxt);

      if (good_commit && !feed_last)      frames_ready <= frames_ready + FW'(1);
      else if (!good_commit && feed_last) frames_ready <= frames_ready - FW'(1);

      feed_k          <= (feed_en && !feed_last) ? feed_k + CW'(1) : '0;
      tvalid_cls_feat <= feed_en;
      cls_frame_last  <= feed_last;
      cls_feat        <= feed_en ? mem[rd_addr] : '0;
      if (feed_last) rd_ptr <= wrap_add(rd_ptr, 32'(N_COEF));

      if (feed_last)              wait_cnt <= '0;
      else if (in_wait && !outcome) wait_cnt <= wait_cnt + WW'(1);

      LSVC_Done   <= outcome;
      cls_timeout <= timeout_hit;
      if (outcome) begin
        if (outcome_p) begin
          hang_cnt    <= HW'(HANGOVER);
          LSVC_Result <= 1'b1;
        end else if (hang_cnt != '0) begin
          hang_cnt    <= hang_cnt - HW'(1);
          LSVC_Result <= 1'b1;
        end else begin
          LSVC_Result <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_vad_frame_scheduler.sv
// Directed bench for vad_frame_scheduler: framing, latency, hangover, overflow,
// timeout, simultaneous commit/consume and reset mid-feed.
module tb_vad_frame_scheduler;
  localparam int N = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid_mfcc_feat, tvalid_prediction, prediction;
  logic [31:0] mfcc_feat;
  logic        tvalid_cls_feat, cls_frame_last, LSVC_Done, LSVC_Result;
  logic        frame_dropped, cls_timeout, busy;
  logic [31:0] cls_feat;

  int errors = 0;
  int checks = 0;

  vad_frame_scheduler #(.N_COEF(13), .FRAMES(2), .HANGOVER(8), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst),
    .tvalid_mfcc_feat(tvalid_mfcc_feat), .mfcc_feat(mfcc_feat),
    .tvalid_cls_feat(tvalid_cls_feat), .cls_feat(cls_feat), .cls_frame_last(cls_frame_last),
    .tvalid_prediction(tvalid_prediction), .prediction(prediction),
    .LSVC_Done(LSVC_Done), .LSVC_Result(LSVC_Result),
    .frame_dropped(frame_dropped), .cls_timeout(cls_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base);
    for (int i = 1; i <= N; i++) begin
      tvalid_mfcc_feat = 1'b1;
      mfcc_feat = 32'(base + i);
      tick();
    end
    tvalid_mfcc_feat = 1'b0;
    mfcc_feat = '0;
  endtask

  // Called at the first point where word 1 of the frame must be visible
  task automatic expect_frame(input int base, input string tag);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_vld"}, 32'(tvalid_cls_feat), 32'd1);
      chk({tag, "_data"}, cls_feat, 32'(base + k + 1));
      chk({tag, "_last"}, 32'(cls_frame_last), 32'(k == N - 1));
      tick();
    end
    chk({tag, "_vld_end"}, 32'(tvalid_cls_feat), 32'd0);
  endtask

  task automatic predict(input logic p);
    tvalid_prediction = 1'b1;
    prediction = p;
    tick();
    tvalid_prediction = 1'b0;
    prediction = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic frame_pred(input int base, input logic p, input logic exp, input string tag);
    send_frame(base);
    repeat (16) tick();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    predict(p);
    chk({tag, "_done"}, 32'(LSVC_Done), 32'd1);
    chk({tag, "_res"}, 32'(LSVC_Result), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    tvalid_mfcc_feat = 1'b0; mfcc_feat = '0;
    tvalid_prediction = 1'b0; prediction = 1'b0;
    #3;
    chk("reset_outs", 32'({tvalid_cls_feat, cls_frame_last, LSVC_Done, LSVC_Result,
                           frame_dropped, cls_timeout, busy}), 32'd0);
    chk("reset_feat", cls_feat, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single frame on an idle system
    send_frame(0);
    chk("lat_c0_vld", 32'(tvalid_cls_feat), 32'd0);
    chk("lat_c0_busy", 32'(busy), 32'd0);
    tick();
    chk("lat_c1_vld", 32'(tvalid_cls_feat), 32'd0);
    chk("lat_c1_busy", 32'(busy), 32'd1);
    tick();
    expect_frame(0, "single");
    repeat (18) tick();
    chk("single_nodone", 32'(LSVC_Done), 32'd0);
    predict(1'b1);
    chk("single_done", 32'(LSVC_Done), 32'd1);
    chk("single_res", 32'(LSVC_Result), 32'd1);
    tick();
    chk("single_done_pulse", 32'(LSVC_Done), 32'd0);
    chk("single_res_hold", 32'(LSVC_Result), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);
    predict(1'b0);
    chk("idle_pred_ignored", 32'(LSVC_Done), 32'd0);

    // Hangover: one speech then ten non-speech decisions
    do_reset();
    frame_pred(0, 1'b1, 1'b1, "hang_sp");
    for (int i = 0; i < 10; i++)
      frame_pred(20 * (i + 1), 1'b0, 1'b1 ^ (i >= 8), $sformatf("hang%0d", i));

    // Overflow: three back-to-back frames, classifier silent
    do_reset();
    send_frame(0);
    send_frame(13);
    send_frame(26);
    chk("ovf_drop", 32'(frame_dropped), 32'd1);
    tick();
    chk("ovf_drop_pulse", 32'(frame_dropped), 32'd0);
    predict(1'b1);
    chk("ovf_done1", 32'(LSVC_Done), 32'd1);
    tick();
    chk("ovf_gap", 32'(tvalid_cls_feat), 32'd0);
    tick();
    expect_frame(13, "ovf_f2");
    predict(1'b0);
    chk("ovf_done2", 32'(LSVC_Done), 32'd1);
    chk("ovf_res2", 32'(LSVC_Result), 32'd1);
    repeat (5) tick();
    chk("ovf_f3_gone", 32'(busy), 32'd0);
    chk("ovf_drop_once", 32'(frame_dropped), 32'd0);
    send_frame(100);
    tick(); tick();
    expect_frame(100, "ovf_align");

    // Timeout with a second frame queued
    do_reset();
    send_frame(0);
    send_frame(13);
    repeat (4096) tick();
    chk("to_early", 32'(cls_timeout), 32'd0);
    chk("to_early_done", 32'(LSVC_Done), 32'd0);
    chk("to_busy", 32'(busy), 32'd1);
    tick();
    chk("to_pulse", 32'(cls_timeout), 32'd1);
    chk("to_done", 32'(LSVC_Done), 32'd1);
    chk("to_res", 32'(LSVC_Result), 32'd0);
    tick();
    chk("to_pulse_end", 32'(cls_timeout), 32'd0);
    chk("to_gap", 32'(tvalid_cls_feat), 32'd0);
    tick();
    expect_frame(13, "to_next");

    // Commit on the last FEED cycle plus a late prediction during FEED
    do_reset();
    send_frame(0);
    tick();
    for (int i = 1; i <= N; i++) begin
      tvalid_mfcc_feat = 1'b1;
      mfcc_feat = 32'(50 + i);
      tvalid_prediction = (i == 6);
      prediction = 1'b1;
      tick();
      if (i == 6) chk("late_pred", 32'(LSVC_Done), 32'd0);
    end
    tvalid_mfcc_feat = 1'b0; mfcc_feat = '0;
    tvalid_prediction = 1'b0; prediction = 1'b0;
    chk("sim_no_drop", 32'(frame_dropped), 32'd0);
    predict(1'b0);
    chk("sim_done", 32'(LSVC_Done), 32'd1);
    chk("sim_res", 32'(LSVC_Result), 32'd0);
    tick();
    chk("sim_gap", 32'(tvalid_cls_feat), 32'd0);
    tick();
    expect_frame(50, "sim_next");

    // Reset in the middle of FEED
    do_reset();
    send_frame(0);
    tick(); tick();
    repeat (5) tick();
    chk("mid_word6", cls_feat, 32'd6);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", 32'({tvalid_cls_feat, cls_frame_last, LSVC_Done, LSVC_Result,
                             frame_dropped, cls_timeout, busy}), 32'd0);
    chk("mid_rst_feat", cls_feat, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_quiet", 32'({tvalid_cls_feat, busy}), 32'd0);
    end
    send_frame(200);
    tick(); tick();
    expect_frame(200, "post_rst");
    predict(1'b1);
    chk("post_rst_done", 32'(LSVC_Done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vad_frame_scheduler.md
Name: vad_frame_scheduler

Overview:
- Sits between the MFCC feature extractor and the classifier pipeline.
- Collects the streamed 32-bit float MFCC coefficients into whole frames in a small circular buffer, then feeds one frame at a time to the classifier.
- Waits for the classifier's prediction, with a timeout, and applies hangover smoothing before driving the final VAD done/result outputs.
- Decouples bursty feature arrival from classifier latency and guarantees frame alignment.

Parameters:
- N_COEF, 13, coefficients per frame (words per classifier input vector).
- FRAMES, 2, frame slots in the buffer; DEPTH = FRAMES*N_COEF words.
- HANGOVER, 8, number of non-speech predictions reported as speech after the last speech prediction.
- TIMEOUT, 4096, maximum cycles spent in WAIT before a prediction is abandoned.

Ports:
- clk  in  1  single clock (fast system clock)
- rst  in  1  asynchronous, active-high reset
- tvalid_mfcc_feat  in  1  coefficient valid strobe, one word per asserted cycle
- mfcc_feat  in  32  float32 coefficient
- tvalid_cls_feat  out  1  coefficient valid toward classifier
- cls_feat  out  32  coefficient toward classifier
- cls_frame_last  out  1  marks the last coefficient of a frame (with tvalid_cls_feat)
- tvalid_prediction  in  1  classifier result strobe
- prediction  in  1  classifier result, 1 = speech
- LSVC_Done  out  1  one-cycle pulse per decided frame
- LSVC_Result  out  1  smoothed VAD decision, held between pulses
- frame_dropped  out  1  one-cycle pulse when an input frame is discarded
- cls_timeout  out  1  one-cycle pulse when WAIT times out
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0; FSM goes to IDLE.
  - wr_ptr, frame_base, rd_ptr, in_cnt, used, frames_ready, hang_cnt and wait_cnt are all 0.
  - Buffer contents are don't-care.
  - Reset mid-frame or mid-FEED discards everything. No partial frame is ever emitted after reset.
- Input side:
  - Every tvalid_mfcc_feat cycle increments in_cnt (wraps N_COEF-1 to 0).
  - If used < DEPTH, the word is written at wr_ptr, then wr_ptr (mod DEPTH) and used increment.
  - Otherwise the word is dropped and the frame is marked bad.
  - On the word with in_cnt = N_COEF-1:
    - Good frame: frame_base <= wr_ptr (next), frames_ready++.
    - Bad frame: wr_ptr <= frame_base, used is reduced by the words written for that frame, frame_dropped pulses on the next cycle.
  - A frame is never split; the classifier sees only complete frames.
- FSM IDLE/FEED/WAIT:
  - IDLE -> FEED when frames_ready > 0.
  - FEED lasts exactly N_COEF cycles, k = 0..N_COEF-1, and reads address (rd_ptr+k) mod DEPTH.
    - Registered read: tvalid_cls_feat/cls_feat appear at cycle k+1.
    - cls_frame_last is asserted with word N_COEF-1.
  - On the last FEED cycle: rd_ptr += N_COEF (mod DEPTH), used -= N_COEF, frames_ready--, go to WAIT, wait_cnt <= 0.
  - WAIT:
    - tvalid_prediction -> IDLE.
    - Otherwise wait_cnt++; when wait_cnt = TIMEOUT-1 -> IDLE with cls_timeout pulse, and the outcome is treated as prediction=0.
  - tvalid_prediction outside WAIT is ignored.
- Simultaneous events:
  - Input frame commit and FEED consume in the same cycle leave frames_ready unchanged.
  - used is updated by +write and -N_COEF together.
  - A write may land in a slot freed in the same cycle only from the next cycle on.
- Smoothing, on an accepted or timed-out outcome p:
  - p=1: hang_cnt <= HANGOVER, result 1.
  - p=0, hang_cnt>0: hang_cnt--, result 1.
  - p=0, hang_cnt=0: result 0.
  - LSVC_Result updates and LSVC_Done pulses one cycle after the outcome cycle.
- Latency: frame-complete to first tvalid_cls_feat is 2 cycles when idle; prediction strobe to LSVC_Done is 1 cycle.
- FRAMES >= 2 lets the next frame fill while the current frame waits.

Test Plan:
- Single frame, idle system: 13 words 1..13 -> tvalid_cls_feat for 13 consecutive cycles, starting 2 cycles after word 13, data 1..13, cls_frame_last on 13. Prediction=1 after 20 cycles -> LSVC_Done pulse 1 cycle later, LSVC_Result=1.
- Hangover, HANGOVER=8: predictions 1 then ten 0s -> LSVC_Result 1 for the first 9 decisions, 0 for the last two.
- Overflow: classifier silent, feed 3 frames back-to-back -> frames 1–2 buffered, frame 3 dropped with one frame_dropped pulse. After predictions, frame 2 is output with correct data and frame alignment is kept.
- Timeout, TIMEOUT=4096: no prediction -> cls_timeout pulse and LSVC_Done with the smoothed 0-outcome exactly 4096 cycles after entering WAIT, then the next buffered frame starts FEED.
- Simultaneous: last word of a new frame arrives in the last FEED cycle -> frames_ready stays 1, the next FEED starts after WAIT with no loss. Late tvalid_prediction during FEED is ignored.
- Reset mid-FEED at word 6 -> all outputs 0 immediately; after release, a fresh frame is fed from word 1 with no stale data.
